// File: rtl/arb_mux_n.sv
// arb_mux_n: N:1 registered arbitrating multiplexer.
// Each cycle one valid/ready input channel is chosen, by round-robin or
// fixed priority, and loaded into a single output register that supports
// valid/ready backpressure. A per-channel lane marks which requests fall
// inside the current search window. A priority encoder then picks the
// lowest marked index.

// Per-channel request qualifier.
// In round-robin mode a request is "high" when its index is at or above
// rr_ptr, so the lowest high request is the first one found scanning
// forward from the pointer. In fixed-priority mode every request counts as
// high, and the lowest index wins.
module arb_mux_lane #(
    parameter int SEL_W = 2,
    parameter int IDX   = 0
) (
    input  logic             valid,
    input  logic             mode,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             hi_req
);
    assign hi_req = valid && (mode || (SEL_W'(IDX) >= rr_ptr));
endmodule

module arb_mux_n #(
    parameter  int DATA_W = 16,
    parameter  int N_CH   = 4,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [N_CH-1:0][DATA_W-1:0] ch_data;
    logic [N_CH-1:0]             hi_req;
    logic [SEL_W-1:0]            rr_ptr;
    logic [SEL_W-1:0]            hi_idx;
    logic [SEL_W-1:0]            lo_idx;
    logic [SEL_W-1:0]            grant_idx;
    logic [SEL_W-1:0]            next_ptr;
    logic                        hi_found;
    logic                        any_valid;
    logic                        load;

    assign ch_data   = in_data;
    assign any_valid = |in_valid;
    // The output register can accept a new item when it is empty or draining.
    assign load      = !out_valid || out_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        arb_mux_lane #(
            .SEL_W (SEL_W),
            .IDX   (i)
        ) u_lane (
            .valid  (in_valid[i]),
            .mode   (mode),
            .rr_ptr (rr_ptr),
            .hi_req (hi_req[i])
        );
    end

    // Two lowest-index encoders: one over the in-window requests and one
    // over all requests. The second covers the wrap past N_CH-1 back to 0.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(i);
            end
            if (in_valid[i]) begin
                lo_idx = SEL_W'(i);
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Pointer successor of the winner. The explicit wrap handles N_CH values
    // that are not a power of two.
    always_comb begin
        next_ptr = '0;
        if (grant_idx != SEL_W'(N_CH - 1)) begin
            next_ptr = grant_idx + SEL_W'(1);
        end
    end

    // Accept strobe: one-hot on the winner, and only when the output
    // register can take the item. It is held low through reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load && any_valid) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    // With no requests, data and sel keep their old values and only valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_sel   <= grant_idx;
                if (!mode) begin
                    rr_ptr <= next_ptr;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised N:1 registered arbitrating multiplexer; successor to the combinational 2:1 datapath mux.
- Selects one of N_CH valid/ready input channels per cycle, using round-robin or fixed-priority arbitration, into a single registered output stage with valid/ready backpressure.
- Used wherever several producers share one datapath sink: register-file write sources, memory request sources, ALU operand sources.

Parameters:
- DATA_W, 16, width of each data channel in bits.
- N_CH, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N_CH), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_valid  input  N_CH  per-channel request/valid.
- in_data  input  N_CH*DATA_W  packed channel data; channel i at bits [i*DATA_W +: DATA_W].
- in_ready  output  N_CH  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a valid item.
- out_data  output  DATA_W  registered selected data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of in-flight state:
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer rr_ptr=0.
  - in_ready=0 during every cycle in which rst_n=0.
  - Any held item is discarded.
- Load enable: load = !out_valid || out_ready. This gives full-throughput pass-through: one item per cycle when the sink is always ready.
- Arbitration is combinational from in_valid, mode and rr_ptr:
  - Round-robin: grant goes to the first asserted in_valid scanning rr_ptr, rr_ptr+1, … N_CH-1, 0, … rr_ptr-1 (wrap-around).
  - Fixed priority: grant goes to the lowest asserted index; rr_ptr is ignored.
- Handshake:
  - in_ready[g]=1 only for the granted index g, and only when load=1 and at least one in_valid is set. All other bits are 0.
  - in_ready is never asserted for a channel whose in_valid=0.
  - A transfer on channel g occurs when in_valid[g] && in_ready[g].
- On a load cycle with a grant:
  - Next edge: out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - In round-robin mode, rr_ptr <= (g+1) mod N_CH.
  - In fixed-priority mode, rr_ptr is unchanged.
- On a load cycle with no requests: out_valid <= 0; out_data and out_sel hold their previous values; rr_ptr unchanged.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and out_valid hold exactly; all in_ready=0; rr_ptr unchanged.
- Latency: 1 cycle from input transfer to out_valid. A simultaneous out_ready and new grant on the same edge replaces the item with no bubble.
- Mode changes take effect at the next arbitration evaluation. Switching back to round-robin resumes from the retained rr_ptr.
- Upstream rules: in_valid may drop without a transfer (no starvation guarantee required). Inputs are not required to hold data across cycles when not granted.
- No combinational path from out_ready to out_data/out_valid. The path from out_ready to in_ready is combinational and intended.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0,… with no channel skipped.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with out_valid=1 and in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0; after release, first grant goes to channel 0.
- RR fairness (N_CH=4, DATA_W=16): in_valid=4'b1111, channel data 0xA000+i, out_ready=1, mode=0 -> out_sel sequence 0,1,2,3,0,1, one item per cycle, out_data matches 0xA000+out_sel.
- Fixed priority: mode=1, in_valid=4'b1010 for 3 cycles -> out_sel=1 every cycle, in_ready=4'b0010; then in_valid=4'b1000 -> out_sel=3.
- Backpressure: item 0x1234 from channel 2 held with out_ready=0 for 4 cycles while other in_valid are set -> out_data=0x1234, out_sel=2 stable, in_ready=0 throughout; when out_ready=1 the next grant loads on that same edge.
- Wrap and sparse requests: mode=0, rr_ptr=3 (after a grant to ch2), in_valid=4'b0011 -> grant ch0, then ch1, then ch0; idle cycle with in_valid=0 and out_ready=1 -> out_valid=0 next cycle.
- Mode switch mid-stream: RR grants 0,1, then mode=1 for 2 cycles (grants 0,0), then mode=0 -> next grant is ch2 (rr_ptr retained at 2).
